majority_voter: RTL and testbench
=================================

MAJORITY_VOTER -- requirements
Module: majority_voter

Interface
REQ-001 Parameter N_IN, default 3, number of voted input channels; legal values are odd, 3..7.
REQ-002 Parameter WIDTH, default 8, bits per channel word.
REQ-003 Parameter FAULT_LIMIT, default 4, consecutive mismatching samples after which a channel is declared faulty; legal range 1..15.
REQ-004 Parameter CNT_W, default 8, width of err_cnt.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  in_data holds a sample.
REQ-008 in_ready  output  1  block accepts a sample this cycle.
REQ-009 in_data  input  N_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-010 out_valid  output  1  out_* fields hold a voted result.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_data  output  WIDTH  bitwise majority word.
REQ-013 out_tie  output  1  at least one bit had no strict majority.
REQ-014 out_mismatch  output  N_IN  channels whose word differed from out_data on this sample.
REQ-015 fault_mask  output  N_IN  channels currently excluded from voting.
REQ-016 fault_clr  input  N_IN  per-channel clear of fault state; single-cycle pulse.
REQ-017 err_cnt  output  CNT_W  count of accepted samples with any active-channel mismatch.

Function
REQ-018 Transfers: an input is accepted when in_valid && in_ready; an output is consumed when out_valid && out_ready.
REQ-019 in_ready = !out_valid || out_ready, combinational; no input-to-input-ready combinational path.
REQ-020 Latency: a sample accepted in cycle t produces out_valid=1 with its result in cycle t+1.
REQ-021 out_valid is set on accept, cleared on consume without a new accept, and held with all out_* fields stable while out_valid && !out_ready.
REQ-022 Active set A = channels with fault_mask bit 0, sampled at the accept cycle; na = |A|.
REQ-023 Per bit b: ones = number of active channels with bit b set; out_data[b] = 1 iff 2*ones > na; if 2*ones == na, out_data[b] = 0 and out_tie = 1.
REQ-024 When na == 0: out_data = 0, out_tie = 1, out_mismatch = 0, no counters change.
REQ-025 out_mismatch[i] = 1 iff channel i is active and its word != out_data; faulty channels always report 0.
REQ-026 Each channel has a consecutive-mismatch counter (4 bits) with states OK (count 0), SUSPECT (1..FAULT_LIMIT-1), and FAULTY (fault_mask bit set).
REQ-027 On accept: an active mismatching channel increments its counter; an active matching channel resets its counter to 0; faulty channels do not change.
REQ-028 When the increment reaches FAULT_LIMIT, the channel enters FAULTY: fault_mask[i] is set in the cycle after the accept, and the counter is cleared.
REQ-029 Entry to FAULTY is suppressed, and the counter saturates at FAULT_LIMIT, if na <= 2 at that accept; the voter never drops below 2 active channels by its own action.
REQ-030 If several channels reach FAULT_LIMIT on the same accept, they are faulted in ascending index order while na after removal stays >= 2; the remaining channels saturate.
REQ-031 fault_clr[i] clears fault_mask[i] and counter i next cycle; it takes priority over a simultaneous increment or fault entry on channel i.
REQ-032 err_cnt increments by 1 on each accept with any out_mismatch bit set, and saturates at 2^CNT_W-1.
REQ-033 Accept and consume in the same cycle are legal; the new result replaces the old one with no bubble.

Reset
REQ-034 On rst=1 at a clock edge: out_valid=0, out_data=0, out_tie=0, out_mismatch=0, fault_mask=0, all counters=0, err_cnt=0; in_ready=1 in the following cycle.
REQ-035 Reset takes priority over any transfer in the same cycle; a held result is discarded.

Verification
REQ-036 Defaults; channels {0x5A,0x5A,0xA5} accepted with out_ready=1 -> next cycle out_data=0x5A, out_mismatch=3'b100, out_tie=0, err_cnt=1.
REQ-037 Channel 2 mismatches on 4 consecutive accepts -> fault_mask=3'b100 after the 4th; next sample {0x0F,0xF0,x} -> out_data=0x00, out_tie=1.
REQ-038 With fault_mask=3'b100, channel 1 mismatches on 4 accepts -> fault_mask stays 3'b100 (REQ-029); then fault_clr=3'b100 -> fault_mask=0 next cycle.
REQ-039 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, exactly one sample accepted; on release, accept and consume in the same cycle, with a new result the next cycle.
REQ-040 rst asserted while out_valid=1 with fault_mask=3'b010 -> all outputs match REQ-034 next cycle; 300 mismatching samples with CNT_W=8 -> err_cnt=255.

Source files
------------

// File: rtl/majority_voter_if.sv
// Handshake and status bundle between a voter and the logic around it.
// The voter connects through the slave modport; its driver connects through master.
interface majority_voter_if #(
  parameter int unsigned N_IN  = 3,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [N_IN*WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic                  out_tie;
  logic [N_IN-1:0]       out_mismatch;
  logic [N_IN-1:0]       fault_mask;
  logic [N_IN-1:0]       fault_clr;
  logic [CNT_W-1:0]      err_cnt;

  modport master (
    output in_valid, in_data, out_ready, fault_clr,
    input  in_ready, out_valid, out_data, out_tie, out_mismatch, fault_mask, err_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready, fault_clr,
    output in_ready, out_valid, out_data, out_tie, out_mismatch, fault_mask, err_cnt
  );
endinterface

// File: rtl/majority_voter.sv
// N-channel bitwise majority voter with per-channel fault isolation,
// one-deep registered output stage and a saturating mismatch counter.
module majority_voter #(
  parameter int unsigned N_IN        = 3,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned FAULT_LIMIT = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic            clk,
  input  logic            rst,
  majority_voter_if.slave bus
);
  localparam int unsigned NA_W = $clog2(N_IN + 1);
  localparam int unsigned CW   = 4;
  localparam int unsigned CW1  = CW + 1;
  localparam logic [CW1-1:0] LIMIT = CW1'(FAULT_LIMIT);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_tie_q, out_tie_d;
  logic [N_IN-1:0]  out_mismatch_q, out_mismatch_d;
  logic [N_IN-1:0]  fault_mask_q, fault_mask_d;
  logic [CW-1:0]    cnt_q [N_IN];
  logic [CW-1:0]    cnt_d [N_IN];
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic             in_ready_c;
  logic             accept;
  logic             consume;
  logic [N_IN-1:0]  active;
  logic [NA_W-1:0]  na;
  logic [NA_W-1:0]  ones;
  logic [NA_W-1:0]  rem;
  logic [CW1-1:0]   inc;
  logic [WIDTH-1:0] vote_data;
  logic             vote_tie;
  logic [N_IN-1:0]  vote_mismatch;

  assign in_ready_c = !out_valid_q || bus.out_ready;
  assign accept     = bus.in_valid && in_ready_c;
  assign consume    = out_valid_q && bus.out_ready;
  assign active     = ~fault_mask_q;

  assign bus.in_ready     = in_ready_c;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_tie      = out_tie_q;
  assign bus.out_mismatch = out_mismatch_q;
  assign bus.fault_mask   = fault_mask_q;
  assign bus.err_cnt      = err_cnt_q;

  // Vote over the active set; na == 0 naturally yields data 0, tie 1, no mismatches.
  always_comb begin
    na            = '0;
    ones          = '0;
    vote_data     = '0;
    vote_tie      = 1'b0;
    vote_mismatch = '0;
    for (int i = 0; i < N_IN; i++) na = na + NA_W'(active[i]);
    for (int b = 0; b < WIDTH; b++) begin
      ones = '0;
      for (int i = 0; i < N_IN; i++)
        ones = ones + NA_W'(active[i] & bus.in_data[i*WIDTH + b]);
      if ({ones, 1'b0} > {1'b0, na})       vote_data[b] = 1'b1;
      else if ({ones, 1'b0} == {1'b0, na}) vote_tie     = 1'b1;
    end
    for (int i = 0; i < N_IN; i++)
      vote_mismatch[i] = active[i] && (bus.in_data[i*WIDTH +: WIDTH] != vote_data);
  end

  // Next-state: output stage, streak counters, fault entry and clear.
  always_comb begin
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    out_tie_d      = out_tie_q;
    out_mismatch_d = out_mismatch_q;
    fault_mask_d   = fault_mask_q;
    cnt_d          = cnt_q;
    err_cnt_d      = err_cnt_q;
    rem            = na;
    inc            = '0;

    if (accept) begin
      out_valid_d    = 1'b1;
      out_data_d     = vote_data;
      out_tie_d      = vote_tie;
      out_mismatch_d = vote_mismatch;
      if ((|vote_mismatch) && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);

      // Ascending index order decides who gets isolated when the active set runs low.
      for (int i = 0; i < N_IN; i++) begin
        if (active[i]) begin
          if (!vote_mismatch[i]) begin
            cnt_d[i] = '0;
          end else begin
            inc = {1'b0, cnt_q[i]} + CW1'(1);
            if (inc < LIMIT) begin
              cnt_d[i] = inc[CW-1:0];
            end else if ((rem > NA_W'(2)) && !bus.fault_clr[i]) begin
              fault_mask_d[i] = 1'b1;
              cnt_d[i]        = '0;
              rem             = rem - NA_W'(1);
            end else begin
              cnt_d[i] = LIMIT[CW-1:0];
            end
          end
        end
      end
    end else if (consume) begin
      out_valid_d = 1'b0;
    end

    for (int i = 0; i < N_IN; i++) begin
      if (bus.fault_clr[i]) begin
        fault_mask_d[i] = 1'b0;
        cnt_d[i]        = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_tie_q      <= 1'b0;
      out_mismatch_q <= '0;
      fault_mask_q   <= '0;
      err_cnt_q      <= '0;
      for (int i = 0; i < N_IN; i++) cnt_q[i] <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_tie_q      <= out_tie_d;
      out_mismatch_q <= out_mismatch_d;
      fault_mask_q   <= fault_mask_d;
      err_cnt_q      <= err_cnt_d;
      cnt_q          <= cnt_d;
    end
  end
endmodule

// File: tb/tb_majority_voter.sv
// Self-checking bench for majority_voter: directed scenarios plus a randomized
// run compared against a behavioural model of the voting and fault rules.
module tb_majority_voter;
  localparam int unsigned N  = 3;
  localparam int unsigned W  = 8;
  localparam int unsigned CW = 8;
  localparam int unsigned FL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  majority_voter_if #(.N_IN(N), .WIDTH(W), .CNT_W(CW)) bus ();

  majority_voter #(.N_IN(N), .WIDTH(W), .FAULT_LIMIT(FL), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit           m_valid;
  logic [W-1:0] m_data;
  bit           m_tie;
  logic [N-1:0] m_mm;
  bit           m_faulty [N];
  int           m_cnt [N];
  int           m_err;
  bit           m_ready;
  logic         ready_seen;

  function automatic logic [N*W-1:0] pk(input logic [W-1:0] c0, input logic [W-1:0] c1,
                                        input logic [W-1:0] c2);
    return {c2, c1, c0};
  endfunction

  function automatic logic [N-1:0] m_mask();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m_faulty[i];
    return r;
  endfunction

  function automatic void model_clock(input bit r, input bit v, input logic [N*W-1:0] d,
                                      input bit ordy, input logic [N-1:0] clr);
    int na;
    int ones;
    int remaining;
    bit newf [N];
    if (r) begin
      m_valid = 0; m_data = '0; m_tie = 0; m_mm = '0; m_err = 0;
      for (int i = 0; i < N; i++) begin m_faulty[i] = 0; m_cnt[i] = 0; end
      return;
    end
    for (int i = 0; i < N; i++) newf[i] = 0;
    if (v && (!m_valid || ordy)) begin
      na = 0;
      for (int i = 0; i < N; i++) if (!m_faulty[i]) na++;
      m_data = '0; m_tie = 0;
      for (int b = 0; b < W; b++) begin
        ones = 0;
        for (int i = 0; i < N; i++) if (!m_faulty[i] && d[i*W + b]) ones++;
        if (2*ones > na) m_data[b] = 1'b1;
        else if (2*ones == na) m_tie = 1;
      end
      m_mm = '0;
      for (int i = 0; i < N; i++) if (!m_faulty[i] && d[i*W +: W] != m_data) m_mm[i] = 1'b1;
      if (m_mm != '0 && m_err < (1 << CW) - 1) m_err++;
      remaining = na;
      for (int i = 0; i < N; i++) begin
        if (m_faulty[i]) continue;
        if (!m_mm[i]) m_cnt[i] = 0;
        else if (m_cnt[i] + 1 < FL) m_cnt[i]++;
        else if (remaining - 1 >= 2 && !clr[i]) begin newf[i] = 1; m_cnt[i] = 0; remaining--; end
        else m_cnt[i] = FL;
      end
      m_valid = 1;
    end else if (m_valid && ordy) begin
      m_valid = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (clr[i]) begin m_faulty[i] = 0; m_cnt[i] = 0; end
      else if (newf[i]) m_faulty[i] = 1;
    end
  endfunction

  // One clock: drive inputs, sample in_ready before the edge, advance the model.
  task automatic cycle(input bit r, input bit v, input logic [N*W-1:0] d, input bit ordy,
                       input logic [N-1:0] clr);
    rst = r; bus.in_valid = v; bus.in_data = d; bus.out_ready = ordy; bus.fault_clr = clr;
    m_ready = !m_valid || ordy;
    #1 ready_seen = bus.in_ready;
    @(posedge clk);
    model_clock(r, v, d, ordy, clr);
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 1, pk(8'h12, 8'h34, 8'h56), 1, '0);
    cycle(1, 0, '0, 1, '0);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", bus.out_data); end
    total++; if (bus.out_tie !== 1'b0) begin bad++; $display("FAIL reset_tie: got %b want 0", bus.out_tie); end
    total++; if (bus.out_mismatch !== 3'b000) begin bad++; $display("FAIL reset_mm: got %b want 000", bus.out_mismatch); end
    total++; if (bus.fault_mask !== 3'b000) begin bad++; $display("FAIL reset_mask: got %b want 000", bus.fault_mask); end
    total++; if (bus.err_cnt !== 8'd0) begin bad++; $display("FAIL reset_err: got %0d want 0", bus.err_cnt); end
    cycle(0, 0, '0, 0, '0);
    total++; if (ready_seen !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready_seen); end
  endtask

  task automatic test_vote_basic();
    cycle(1, 0, '0, 1, '0);
    cycle(0, 1, pk(8'h5A, 8'h5A, 8'hA5), 1, '0);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", bus.out_valid); end
    total++; if (bus.out_data !== 8'h5A) begin bad++; $display("FAIL basic_data: got %h want 5a", bus.out_data); end
    total++; if (bus.out_mismatch !== 3'b100) begin bad++; $display("FAIL basic_mm: got %b want 100", bus.out_mismatch); end
    total++; if (bus.out_tie !== 1'b0) begin bad++; $display("FAIL basic_tie: got %b want 0", bus.out_tie); end
    total++; if (bus.err_cnt !== 8'd1) begin bad++; $display("FAIL basic_err: got %0d want 1", bus.err_cnt); end
    cycle(0, 1, pk(8'hF0, 8'h0F, 8'hFF), 1, '0);
    total++; if (bus.out_data !== 8'hFF) begin bad++; $display("FAIL bitwise_data: got %h want ff", bus.out_data); end
    total++; if (bus.out_mismatch !== 3'b011) begin bad++; $display("FAIL bitwise_mm: got %b want 011", bus.out_mismatch); end
    total++; if (bus.err_cnt !== 8'd2) begin bad++; $display("FAIL bitwise_err: got %0d want 2", bus.err_cnt); end
    cycle(0, 0, '0, 1, '0);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL drain_valid: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_fault_entry();
    logic [N-1:0] exp_mask;
    cycle(1, 0, '0, 1, '0);
    for (int k = 1; k <= 4; k++) begin
      cycle(0, 1, pk(8'h11, 8'h11, 8'h22), 1, '0);
      exp_mask = (k == 4) ? 3'b100 : 3'b000;
      total++; if (bus.fault_mask !== exp_mask) begin bad++; $display("FAIL fault_entry_mask[%0d]: got %b want %b", k, bus.fault_mask, exp_mask); end
    end
    cycle(0, 1, pk(8'h0F, 8'hF0, 8'h33), 1, '0);
    total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL two_ch_data: got %h want 00", bus.out_data); end
    total++; if (bus.out_tie !== 1'b1) begin bad++; $display("FAIL two_ch_tie: got %b want 1", bus.out_tie); end
    total++; if (bus.out_mismatch !== 3'b011) begin bad++; $display("FAIL two_ch_mm: got %b want 011", bus.out_mismatch); end
  endtask

  task automatic test_fault_suppress_clear();
    for (int k = 1; k <= 5; k++) begin
      cycle(0, 1, pk(8'h00, 8'h0F, 8'hEE), 1, '0);
      total++; if (bus.fault_mask !== 3'b100) begin bad++; $display("FAIL suppress_mask[%0d]: got %b want 100", k, bus.fault_mask); end
      total++; if (bus.out_mismatch !== 3'b010) begin bad++; $display("FAIL suppress_mm[%0d]: got %b want 010", k, bus.out_mismatch); end
    end
    cycle(0, 0, '0, 1, 3'b100);
    total++; if (bus.fault_mask !== 3'b000) begin bad++; $display("FAIL clear_mask: got %b want 000", bus.fault_mask); end
    cycle(0, 1, pk(8'h5A, 8'h5A, 8'h5A), 1, '0);
    total++; if (bus.out_mismatch !== 3'b000) begin bad++; $display("FAIL clear_mm: got %b want 000", bus.out_mismatch); end
  endtask

  task automatic test_clr_priority();
    cycle(1, 0, '0, 1, '0);
    for (int k = 0; k < 3; k++) cycle(0, 1, pk(8'h01, 8'h01, 8'h80), 1, '0);
    cycle(0, 1, pk(8'h01, 8'h01, 8'h80), 1, 3'b100);
    total++; if (bus.fault_mask !== 3'b000) begin bad++; $display("FAIL clr_prio_mask: got %b want 000", bus.fault_mask); end
    cycle(0, 1, pk(8'h01, 8'h01, 8'h80), 1, '0);
    total++; if (bus.fault_mask !== 3'b000) begin bad++; $display("FAIL clr_prio_cnt: got %b want 000", bus.fault_mask); end
  endtask

  task automatic test_back_to_back();
    cycle(1, 0, '0, 1, '0);
    cycle(0, 1, pk(8'h5A, 8'h5A, 8'hA5), 0, '0);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL stall_first_valid: got %b want 1", bus.out_valid); end
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, pk(8'h33, 8'h33, 8'h3C), 0, '0);
      total++; if (ready_seen !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d]: got %b want 0", k, ready_seen); end
      total++; if (bus.out_data !== 8'h5A || bus.out_mismatch !== 3'b100 || bus.out_valid !== 1'b1)
        begin bad++; $display("FAIL stall_hold[%0d]: got %h/%b/%b want 5a/100/1", k, bus.out_data, bus.out_mismatch, bus.out_valid); end
      total++; if (bus.err_cnt !== 8'd1) begin bad++; $display("FAIL stall_err[%0d]: got %0d want 1", k, bus.err_cnt); end
    end
    cycle(0, 1, pk(8'h33, 8'h33, 8'h3C), 1, '0);
    total++; if (ready_seen !== 1'b1) begin bad++; $display("FAIL release_ready: got %b want 1", ready_seen); end
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h33) begin bad++; $display("FAIL release_data: got %b/%h want 1/33", bus.out_valid, bus.out_data); end
    total++; if (bus.err_cnt !== 8'd2) begin bad++; $display("FAIL release_err: got %0d want 2", bus.err_cnt); end
  endtask

  task automatic test_reset_midstream();
    logic [N*W-1:0] d;
    cycle(1, 0, '0, 1, '0);
    for (int k = 0; k < 4; k++) cycle(0, 1, pk(8'h10, 8'h20, 8'h10), 1, '0);
    total++; if (bus.fault_mask !== 3'b010) begin bad++; $display("FAIL mid_mask: got %b want 010", bus.fault_mask); end
    cycle(0, 1, pk(8'h10, 8'h20, 8'h10), 0, '0);
    cycle(1, 1, pk(8'h77, 8'h77, 8'h70), 0, '0);
    total++; if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_tie !== 1'b0 || bus.out_mismatch !== 3'b000)
      begin bad++; $display("FAIL mid_out: got %b/%h/%b/%b want 0/00/0/000", bus.out_valid, bus.out_data, bus.out_tie, bus.out_mismatch); end
    total++; if (bus.fault_mask !== 3'b000 || bus.err_cnt !== 8'd0) begin bad++; $display("FAIL mid_state: got %b/%0d want 000/0", bus.fault_mask, bus.err_cnt); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b want 1", bus.in_ready); end
    // Rotate the odd channel out so every sample mismatches but no channel faults
    for (int k = 0; k < 300; k++) begin
      d = '0;
      d[(k % 3)*W +: W] = 8'hFF;
      cycle(0, 1, d, 1, '0);
      if (k == 253) begin
        total++; if (bus.err_cnt !== 8'd254) begin bad++; $display("FAIL sat_err_254: got %0d want 254", bus.err_cnt); end
      end
    end
    cycle(0, 0, '0, 1, '0);
    total++; if (bus.err_cnt !== 8'd255) begin bad++; $display("FAIL sat_err: got %0d want 255", bus.err_cnt); end
    total++; if (bus.fault_mask !== 3'b000) begin bad++; $display("FAIL sat_mask: got %b want 000", bus.fault_mask); end
  endtask

  task automatic test_random();
    logic [W-1:0]   base;
    logic [W-1:0]   w;
    logic [N*W-1:0] d;
    logic [N-1:0]   clr;
    int             bad_ch;
    bit             r;
    cycle(1, 0, '0, 1, '0);
    bad_ch = 0;
    for (int k = 0; k < 600; k++) begin
      if (k % 60 == 0) bad_ch = $urandom_range(0, N - 1);
      base = W'($urandom);
      for (int i = 0; i < N; i++) begin
        w = base;
        if ($urandom_range(0, 99) < ((i == bad_ch) ? 85 : 8)) w = base ^ W'($urandom_range(1, 255));
        d[i*W +: W] = w;
      end
      clr = ($urandom_range(0, 99) < 4) ? N'($urandom_range(1, 7)) : '0;
      r   = ($urandom_range(0, 199) == 0);
      cycle(r, $urandom_range(0, 99) < 80, d, $urandom_range(0, 99) < 70, clr);
      total++; if (ready_seen !== m_ready) begin bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", k, ready_seen, m_ready); end
      total++; if (bus.out_valid !== m_valid) begin bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", k, bus.out_valid, m_valid); end
      total++; if (bus.out_data !== m_data) begin bad++; $display("FAIL rnd_data[%0d]: got %h want %h", k, bus.out_data, m_data); end
      total++; if (bus.out_tie !== m_tie) begin bad++; $display("FAIL rnd_tie[%0d]: got %b want %b", k, bus.out_tie, m_tie); end
      total++; if (bus.out_mismatch !== m_mm) begin bad++; $display("FAIL rnd_mm[%0d]: got %b want %b", k, bus.out_mismatch, m_mm); end
      total++; if (bus.fault_mask !== m_mask()) begin bad++; $display("FAIL rnd_mask[%0d]: got %b want %b", k, bus.fault_mask, m_mask()); end
      total++; if (bus.err_cnt !== CW'(m_err)) begin bad++; $display("FAIL rnd_err[%0d]: got %0d want %0d", k, bus.err_cnt, m_err); end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1; bus.fault_clr = '0;
    test_reset();
    test_vote_basic();
    test_fault_entry();
    test_fault_suppress_clear();
    test_clr_priority();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
